// File: rtl/matrix_load_sequencer_pkg.sv
// Shared definitions for the matrix operand load sequencer: default buffer
// limits, word width, state encoding and a small width helper.
package matrix_load_sequencer_pkg;

  localparam int MAX_M_DEF = 100;
  localparam int MAX_K_DEF = 100;
  localparam int MAX_N_DEF = 100;
  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    KICK,
    WAIT_ENG
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_load_sequencer_if.sv
// Job request, operand stream, engine handshake and operand buffers shared
// between the load sequencer (slave) and its surroundings (master).
interface matrix_load_sequencer_if
  import matrix_load_sequencer_pkg::*;
#(
  parameter int MAX_M = MAX_M_DEF,
  parameter int MAX_K = MAX_K_DEF,
  parameter int MAX_N = MAX_N_DEF
);
  localparam int ADDR_M_BITS = $clog2(MAX_M);
  localparam int ADDR_K_BITS = $clog2(MAX_K);
  localparam int ADDR_N_BITS = $clog2(MAX_N);

  logic                   job_start;
  logic [ADDR_M_BITS:0]   M_in;
  logic [ADDR_K_BITS:0]   K_in;
  logic [ADDR_N_BITS:0]   N_in;
  logic                   s_valid;
  logic [WORD_BITS-1:0]   s_data;
  logic                   s_ready;
  logic [ADDR_M_BITS:0]   M_val;
  logic [ADDR_K_BITS:0]   K_val;
  logic [ADDR_N_BITS:0]   N_val;
  logic [WORD_BITS-1:0]   matrix_A [MAX_M*MAX_K];
  logic [WORD_BITS-1:0]   matrix_B [MAX_K*MAX_N];
  logic                   mm_start;
  logic                   mm_done;
  logic                   busy;
  logic                   job_done;
  logic                   job_err;

  modport master (
    output job_start, M_in, K_in, N_in, s_valid, s_data, mm_done,
    input  s_ready, M_val, K_val, N_val, matrix_A, matrix_B,
           mm_start, busy, job_done, job_err
  );

  modport slave (
    input  job_start, M_in, K_in, N_in, s_valid, s_data, mm_done,
    output s_ready, M_val, K_val, N_val, matrix_A, matrix_B,
           mm_start, busy, job_done, job_err
  );

endinterface

// File: rtl/matrix_load_sequencer_counter.sv
// Stream word counter: clear, increment, and flag the last word of a
// segment whose length is supplied by the caller.
module matrix_load_sequencer_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [CNT_BITS-1:0] len_i,
  output logic [CNT_BITS-1:0] cnt_o,
  output logic                last_o
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == (len_i - CNT_BITS'(1)));

endmodule

// File: rtl/matrix_load_sequencer.sv
// Accepts an M/K/N job, loads A then B from a valid/ready word stream into
// the operand buffers, kicks the engine and reports completion.
module matrix_load_sequencer
  import matrix_load_sequencer_pkg::*;
#(
  parameter int MAX_M = MAX_M_DEF,
  parameter int MAX_K = MAX_K_DEF,
  parameter int MAX_N = MAX_N_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_load_sequencer_if.slave io
);

  localparam int ADDR_M_BITS = $clog2(MAX_M);
  localparam int ADDR_K_BITS = $clog2(MAX_K);
  localparam int ADDR_N_BITS = $clog2(MAX_N);
  localparam int ADDR_A_BITS = $clog2(MAX_M*MAX_K);
  localparam int ADDR_B_BITS = $clog2(MAX_K*MAX_N);
  localparam int CNT_BITS    = max_int(ADDR_A_BITS, ADDR_B_BITS) + 1;
  localparam int DM          = ADDR_M_BITS + 1;
  localparam int DK          = ADDR_K_BITS + 1;
  localparam int DN          = ADDR_N_BITS + 1;

  localparam logic [DM-1:0] M_LIMIT = DM'(MAX_M);
  localparam logic [DK-1:0] K_LIMIT = DK'(MAX_K);
  localparam logic [DN-1:0] N_LIMIT = DN'(MAX_N);

  state_e              state_q;
  logic                s_ready_q;
  logic                mm_start_q;
  logic                busy_q;
  logic                job_done_q;
  logic                job_err_q;
  logic [DM-1:0]       m_q;
  logic [DK-1:0]       k_q;
  logic [DN-1:0]       n_q;

  logic                dims_ok;
  logic                accept;
  logic                xfer;
  logic                cnt_clr;
  logic                cnt_last;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_len;
  logic [CNT_BITS-1:0] size_a;
  logic [CNT_BITS-1:0] size_b;
  logic [ADDR_A_BITS-1:0] idx_a;
  logic [ADDR_B_BITS-1:0] idx_b;

  assign dims_ok = (io.M_in != '0) && (io.K_in != '0) && (io.N_in != '0) &&
                   (io.M_in <= M_LIMIT) && (io.K_in <= K_LIMIT) &&
                   (io.N_in <= N_LIMIT);
  assign accept  = (state_q == IDLE) && io.job_start && dims_ok;
  assign xfer    = io.s_valid && s_ready_q;

  // Segment lengths come from the latched dimensions, never the live inputs.
  assign size_a  = CNT_BITS'(m_q) * CNT_BITS'(k_q);
  assign size_b  = CNT_BITS'(k_q) * CNT_BITS'(n_q);
  assign cnt_len = (state_q == LOAD_A) ? size_a : size_b;
  assign cnt_clr = accept || ((state_q == LOAD_A) && xfer && cnt_last);

  matrix_load_sequencer_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_word_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (xfer),
    .len_i  (cnt_len),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_ready_q  <= 1'b0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
    end else begin
      mm_start_q <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io.job_start) begin
            if (dims_ok) begin
              m_q       <= io.M_in;
              k_q       <= io.K_in;
              n_q       <= io.N_in;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b1;
              state_q   <= LOAD_A;
            end else begin
              job_err_q <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          // s_ready stays high across the A/B boundary: no bubble.
          if (xfer && cnt_last) begin
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer && cnt_last) begin
            s_ready_q  <= 1'b0;
            mm_start_q <= 1'b1;
            state_q    <= KICK;
          end
        end
        KICK: begin
          state_q <= WAIT_ENG;
        end
        WAIT_ENG: begin
          if (io.mm_done) begin
            job_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign idx_a = ADDR_A_BITS'(cnt);
  assign idx_b = ADDR_B_BITS'(cnt);

  // Buffers are deliberately not reset; a new job simply overwrites them.
  always_ff @(posedge clk) begin
    if (xfer && (state_q == LOAD_A)) begin
      io.matrix_A[idx_a] <= io.s_data;
    end
    if (xfer && (state_q == LOAD_B)) begin
      io.matrix_B[idx_b] <= io.s_data;
    end
  end

  assign io.s_ready  = s_ready_q;
  assign io.mm_start = mm_start_q;
  assign io.busy     = busy_q;
  assign io.job_done = job_done_q;
  assign io.job_err  = job_err_q;
  assign io.M_val    = m_q;
  assign io.K_val    = k_q;
  assign io.N_val    = n_q;

endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
- Upstream feeder for the matrix multiply engine.
- Accepts a job (M, K, N dimensions), then receives A row-major followed by B row-major as a valid/ready stream of 32-bit words into the operand buffers.
- Pulses the engine start, waits for engine done, then reports job completion.
- Owns all operand-buffer writes and the latched dimensions the engine reads.

Parameters:
- MAX_M, 100, maximum rows of A/C
- MAX_K, 100, maximum inner dimension
- MAX_N, 100, maximum columns of B/C
- ADDR_M_BITS / ADDR_K_BITS / ADDR_N_BITS, $clog2(MAX_x), dimension index widths
- ADDR_A_BITS / ADDR_B_BITS, $clog2(MAX_M*MAX_K) / $clog2(MAX_K*MAX_N), buffer index widths

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  request new job; sampled only in IDLE
- M_in / K_in / N_in  in  ADDR_x_BITS+1  job dimensions, sampled with job_start
- s_valid  in  1  stream word valid
- s_data  in  32  stream word (fp32 bit pattern, not interpreted)
- s_ready  out  1  sequencer accepts word
- M_val / K_val / N_val  out  ADDR_x_BITS+1  latched dimensions to engine
- matrix_A  out  32 x MAX_M*MAX_K  operand buffer A
- matrix_B  out  32 x MAX_K*MAX_N  operand buffer B
- mm_start  out  1  one-cycle engine start pulse
- mm_done  in  1  engine completion pulse
- busy  out  1  job in progress
- job_done  out  1  one-cycle completion pulse
- job_err  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset: state IDLE, s_ready=0, mm_start=0, busy=0, job_done=0, job_err=0, M_val/K_val/N_val=0, counters=0. Buffer contents not reset.
- States: IDLE -> LOAD_A -> LOAD_B -> KICK -> WAIT_ENG -> IDLE.
- IDLE, job_start=1:
  - any dimension 0, or M_in>MAX_M, K_in>MAX_K, N_in>MAX_N: job_err=1 for one cycle, stay IDLE, latched dimensions unchanged.
  - otherwise: latch dimensions, clear word counter, busy=1, go to LOAD_A.
- s_ready=1 exactly in LOAD_A and LOAD_B (registered, asserted the cycle after entry). Transfer = s_valid & s_ready on a rising edge. s_valid with s_ready=0 is ignored; words are not buffered.
- LOAD_A: each transfer writes matrix_A[cnt] <= s_data and increments cnt.
  - On the transfer with cnt==M*K-1: cnt<=0, go to LOAD_B, s_ready stays 1 (no bubble).
- LOAD_B: each transfer writes matrix_B[cnt] <= s_data.
  - On the transfer with cnt==K*N-1: s_ready<=0, go to KICK.
- Counter width is max(ADDR_A_BITS, ADDR_B_BITS)+1; products M*K and K*N are computed at that width from the latched values.
- KICK: mm_start=1 for exactly one cycle, go to WAIT_ENG.
- WAIT_ENG: mm_start=0. On mm_done=1: job_done=1 for one cycle, busy=0, go to IDLE. Latched dimensions and buffers hold until the next accepted job so the engine and C readers stay valid.
- job_start while busy is ignored (no error, no restart).
- mm_done outside WAIT_ENG is ignored.
- Minimum latency for 1x1x1: job_start accepted at cycle 0, s_ready high at cycle 1, two words at cycles 1-2, mm_start at cycle 3.
- Reset mid-job: immediate return to reset values. Partially written buffers are left as is; the next job overwrites them.
- Single driver: this block is the only writer of matrix_A/matrix_B; the engine reads them only after mm_start.

Decomposition:
- Shared package matmul_pkg: MAX_M/MAX_K/MAX_N defaults, derived ADDR_* widths, state encoding localparams (IDLE/LOAD_A/LOAD_B/KICK/WAIT_ENG).
- No sub-module required. An optional stream_word_counter (load, increment, terminal-count compare) is the one natural split.

Test Plan:
- 2x3x2 job with A=1..6 and B=7..12 streamed with continuous s_valid -> matrix_A[0..5]=1..6, matrix_B[0..5]=7..12, mm_start exactly once at cycle 13; mm_done driven 5 cycles later -> job_done one cycle later, busy low.
- Same job with s_valid toggled 1,0,0,1 -> identical buffer contents, no duplicated or dropped words, word count 12.
- job_start with K_in=0, then with M_in=MAX_M+1 -> job_err pulse each time, busy stays 0, s_ready stays 0, M_val/K_val/N_val unchanged.
- job_start re-asserted during LOAD_B and during WAIT_ENG -> no effect, job completes normally; a spurious mm_done in LOAD_A is ignored.
- rst_n dropped after 3 of 6 A words -> all outputs at reset values asynchronously; a fresh 1x1x1 job (A=0x3F800000, B=0x40000000) then loads correctly and issues mm_start.
- Back-to-back jobs 1x1x1 then 3x2x1 -> second job's M_val/K_val/N_val=3/2/1, matrix_A[0..5] and matrix_B[0..1] hold the new data.
